add_16bit_nibble_seq: RTL

ADD_16BIT_NIBBLE_SEQ -- requirements
Module: add_16bit_nibble_seq

---
 rtl/add_16bit_nibble_seq.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/add_16bit_nibble_seq.sv
// ---------------------------------------------------------------------------
// add_16bit_nibble_seq
//
// Purpose:
//   16-bit adder/subtractor that computes its result over four clock cycles.
//   One 4-bit carry-lookahead adder is shared across the four nibbles, and
//   the carry ripples between cycles through a carry register.
//
//   Operation sequence:
//     IDLE : waits for start, then captures the operands.
//     RUN  : four cycles, one nibble per cycle, starting with nibble 0.
//     DONE : one cycle with done high, then returns to IDLE.
//   The outputs change only on the last RUN edge.
//
// Ports:
//   clk    in   1   sole clock, rising edge
//   rst_n  in   1   synchronous active-low reset
//   start  in   1   request pulse, sampled only in IDLE
//   sub    in   1   0 = a+b, 1 = a-b, sampled with start
//   a      in  16   operand A, sampled with start
//   b      in  16   operand B, sampled with start
//   busy   out  1   high whenever the state is not IDLE
//   done   out  1   one-cycle completion pulse
//   sum    out 16   registered result
//   cout   out  1   carry out of bit 15 (for sub: 1 = no borrow)
//   ovfl   out  1   two's-complement signed overflow
//   zero   out  1   result equals 0x0000
// ---------------------------------------------------------------------------

// 4-bit carry-lookahead adder. All carries are formed directly from the
// generate and propagate terms, so none of them ripples through another.
module add_4bit_lookahead (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       c4
);

    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [4:0] c_s;

    // Generate/propagate terms and the flattened lookahead carry equations.
    always_comb begin
        g_s = a & b;
        p_s = a ^ b;
        c_s = 5'b0_0000;
        c_s[0] = cin;
        c_s[1] = g_s[0] | (p_s[0] & cin);
        c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
        c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
               | (p_s[2] & p_s[1] & p_s[0] & cin);
        c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
               | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
               | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);
        sum = p_s ^ c_s[3:0];
        c4  = c_s[4];
    end

endmodule

module add_16bit_nibble_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sub,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] sum,
    output logic        cout,
    output logic        ovfl,
    output logic        zero
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_r;
    logic [1:0]  idx_r;
    logic        carry_r;
    logic [15:0] opa_r;
    logic [15:0] opb_r;
    logic [15:0] acc_r;
    logic        busy_r;
    logic        done_r;
    logic [15:0] sum_r;
    logic        cout_r;
    logic        ovfl_r;
    logic        zero_r;

    logic [3:0]  nib_a_s;
    logic [3:0]  nib_b_s;
    logic [3:0]  add_sum_s;
    logic        add_c4_s;
    logic [15:0] full_sum_s;
    logic        full_ovfl_s;

    // Select the operand nibbles for the current nibble index.
    always_comb begin
        nib_a_s = 4'h0;
        nib_b_s = 4'h0;
        case (idx_r)
            2'd0: begin
                nib_a_s = opa_r[3:0];
                nib_b_s = opb_r[3:0];
            end
            2'd1: begin
                nib_a_s = opa_r[7:4];
                nib_b_s = opb_r[7:4];
            end
            2'd2: begin
                nib_a_s = opa_r[11:8];
                nib_b_s = opb_r[11:8];
            end
            2'd3: begin
                nib_a_s = opa_r[15:12];
                nib_b_s = opb_r[15:12];
            end
            default: begin
                nib_a_s = 4'h0;
                nib_b_s = 4'h0;
            end
        endcase
    end

    // The single shared nibble adder.
    add_4bit_lookahead u_cla (
        .a   (nib_a_s),
        .b   (nib_b_s),
        .cin (carry_r),
        .sum (add_sum_s),
        .c4  (add_c4_s)
    );

    // Full result as it will exist after the final nibble. This value is used
    // only on the i=3 edge, when nibbles 0..2 are already in the accumulator.
    // opB already holds ~b for subtraction, so one overflow rule covers both
    // operations.
    always_comb begin
        full_sum_s  = {add_sum_s, acc_r[11:0]};
        full_ovfl_s = (opa_r[15] == opb_r[15]) && (full_sum_s[15] != opa_r[15]);
    end

    // Sequencer, nibble accumulator and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= 2'd0;
            carry_r <= 1'b0;
            opa_r   <= 16'h0000;
            opb_r   <= 16'h0000;
            acc_r   <= 16'h0000;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sum_r   <= 16'h0000;
            cout_r  <= 1'b0;
            ovfl_r  <= 1'b0;
            zero_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        opa_r   <= a;
                        // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
                        opb_r   <= sub ? ~b : b;
                        carry_r <= sub;
                        idx_r   <= 2'd0;
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    acc_r[{idx_r, 2'b00} +: 4] <= add_sum_s;
                    carry_r <= add_c4_s;
                    idx_r   <= idx_r + 2'd1;
                    if (idx_r == 2'd3) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        sum_r   <= full_sum_s;
                        cout_r  <= add_c4_s;
                        ovfl_r  <= full_ovfl_s;
                        zero_r  <= (full_sum_s == 16'h0000);
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    idx_r   <= 2'd0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovfl = ovfl_r;
    assign zero = zero_r;

endmodule
